// File: rtl/key_scan_pkg.sv
// Shared types for the keypad scanner: FSM states, per-frame scan results
// and the keypad position-to-digit mapping consumed by downstream lock logic.
package key_scan_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } scan_state_t;

   typedef enum logic [1:0] {
      FR_NONE   = 2'd0,
      FR_SINGLE = 2'd1,
      FR_MULTI  = 2'd2
   } frame_res_t;

   // Standard 4x4 legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E, # = F.
   function automatic logic [3:0] pos_to_digit(input logic [3:0] pos);
      logic [3:0] digit;
      case (pos)
         4'd0:    digit = 4'h1;
         4'd1:    digit = 4'h2;
         4'd2:    digit = 4'h3;
         4'd3:    digit = 4'hA;
         4'd4:    digit = 4'h4;
         4'd5:    digit = 4'h5;
         4'd6:    digit = 4'h6;
         4'd7:    digit = 4'hB;
         4'd8:    digit = 4'h7;
         4'd9:    digit = 4'h8;
         4'd10:   digit = 4'h9;
         4'd11:   digit = 4'hC;
         4'd12:   digit = 4'hE;
         4'd13:   digit = 4'h0;
         4'd14:   digit = 4'hF;
         default: digit = 4'hD;
      endcase
      return digit;
   endfunction

endpackage

// File: rtl/key_scan_timer.sv
// Row-line synchronizer and scan tick divider for the keypad scanner.
// tick is high for one clk every SCAN_DIV cycles, when the divider sits at its last value.
module key_scan_timer
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_ROWS-1:0] row_sync,
   output logic                tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

   logic [NUM_ROWS-1:0] row_meta_reg;
   logic [NUM_ROWS-1:0] row_sync_reg;
   logic [CW-1:0]       div_cnt_reg;

   // Idle (released) rows read high, so the synchronizer resets to all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_reg <= '1;
         row_sync_reg <= '1;
         div_cnt_reg  <= '0;
      end else begin
         row_meta_reg <= row;
         row_sync_reg <= row_meta_reg;
         div_cnt_reg  <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + CW'(1);
      end
   end

   assign row_sync = row_sync_reg;
   assign tick     = (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: rotates one active-low column per tick, classifies each
// four-column frame and debounces press/release at frame granularity.
module key_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV   = 5,
   parameter int DEB_FRAMES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES);

   logic [3:0]  row_sync;
   logic        tick;
   logic [3:0]  row_low;

   logic [3:0]  col_reg;
   logic [1:0]  col_idx_reg;
   logic [1:0]  hits_reg;
   logic [3:0]  pos_reg;

   scan_state_t state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next, cnt_inc;
   logic [3:0]  cand_reg, cand_next;
   logic [3:0]  key_code_reg, key_code_next;
   logic        key_valid_reg, key_held_reg;
   logic        accept;

   logic [2:0]  col_hits;
   logic [2:0]  hits_tot;
   logic [1:0]  hits_sum;
   logic [1:0]  row_idx;
   logic [3:0]  pos_sum;
   logic        frame_end;
   frame_res_t  frame_res;

   key_scan_timer #(
      .SCAN_DIV (SCAN_DIV)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .row_sync (row_sync),
      .tick     (tick)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row_low
         assign row_low[gi] = ~row_sync[gi];
      end
   endgenerate

   // Hits seen in the column being sampled now, merged with the frame so far.
   always_comb begin
      col_hits = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
      row_idx  = 2'd0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (row_low[r]) row_idx = 2'(r);
      end
      hits_tot = {1'b0, hits_reg} + col_hits;
      hits_sum = (hits_tot >= 3'd2) ? 2'd2 : hits_tot[1:0];
      pos_sum  = (hits_reg == 2'd0 && col_hits == 3'd1) ? {row_idx, col_idx_reg} : pos_reg;
      frame_end = tick && (col_idx_reg == 2'd3);
      case (hits_sum)
         2'd0:    frame_res = FR_NONE;
         2'd1:    frame_res = FR_SINGLE;
         default: frame_res = FR_MULTI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_reg     <= 4'b1110;
         col_idx_reg <= 2'd0;
         hits_reg    <= 2'd0;
         pos_reg     <= 4'd0;
      end else if (tick) begin
         col_reg     <= {col_reg[2:0], col_reg[3]};
         col_idx_reg <= col_idx_reg + 2'd1;
         hits_reg    <= frame_end ? 2'd0 : hits_sum;
         pos_reg     <= frame_end ? 4'd0 : pos_sum;
      end
   end

   assign cnt_inc = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      cand_next     = cand_reg;
      key_code_next = key_code_reg;
      accept        = 1'b0;
      if (frame_end) begin
         case (state_reg)
            ST_IDLE: begin
               if (frame_res == FR_SINGLE) begin
                  cand_next = pos_sum;
                  if (DEB_LAST <= 4'd1) begin
                     accept = 1'b1;
                  end else begin
                     state_next = ST_DEBOUNCE;
                     cnt_next   = 4'd1;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (frame_res == FR_SINGLE && pos_sum == cand_reg) begin
                  if (cnt_inc >= DEB_LAST) accept = 1'b1;
                  else                     cnt_next = cnt_inc;
               end else begin
                  state_next = ST_IDLE;
                  cnt_next   = 4'd0;
               end
            end
            ST_HELD: begin
               // Only clean release frames count; any press restarts the release count.
               if (frame_res == FR_NONE) begin
                  if (cnt_inc >= DEB_LAST) begin
                     state_next = ST_IDLE;
                     cnt_next   = 4'd0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end else begin
                  cnt_next = 4'd0;
               end
            end
            default: begin
               state_next = ST_IDLE;
               cnt_next   = 4'd0;
            end
         endcase
         if (accept) begin
            key_code_next = cand_next;
            state_next    = ST_HELD;
            cnt_next      = 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= 4'd0;
         cand_reg      <= 4'd0;
         key_code_reg  <= 4'd0;
         key_valid_reg <= 1'b0;
         key_held_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         cand_reg      <= cand_next;
         key_code_reg  <= key_code_next;
         key_valid_reg <= accept;
         key_held_reg  <= (state_next == ST_HELD);
      end
   end

   assign col       = col_reg;
   assign key_code  = key_code_reg;
   assign key_valid = key_valid_reg;
   assign key_held  = key_held_reg;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a keypad model drives row from the pressed-key mask and
// a frame-level reference model predicts key_valid/key_code/key_held.
module tb_key_scan;

   localparam int SCAN_DIV   = 5;
   localparam int DEB_FRAMES = 3;
   localparam int FRAME_CLK  = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] pressed = 16'h0000;

   int checks = 0;
   int errors = 0;
   int dut_pulses = 0;

   // Reference model state: 0 idle, 1 debounce, 2 held
   int         m_st = 0;
   int         m_cnt = 0;
   logic [3:0] m_cand = 4'd0;
   logic [3:0] m_code = 4'd0;

   key_scan #(
      .SCAN_DIV   (SCAN_DIV),
      .DEB_FRAMES (DEB_FRAMES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its row to its column line.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_cnt  = 0;
      m_cand = 4'd0;
      m_code = 4'd0;
   endtask

   // One frame of the debounce rules applied to the whole-frame key set.
   task automatic model_frame(input logic [15:0] mask, output bit acc);
      int n;
      int k;
      n   = $countones(mask);
      k   = 0;
      acc = 1'b0;
      for (int i = 0; i < 16; i++) if (mask[i]) k = i;
      if (m_st == 0) begin
         if (n == 1) begin
            m_cand = 4'(k);
            m_cnt  = 1;
            if (m_cnt >= DEB_FRAMES) acc = 1'b1;
            else                     m_st = 1;
         end
      end else if (m_st == 1) begin
         if (n == 1 && 4'(k) == m_cand) begin
            m_cnt++;
            if (m_cnt >= DEB_FRAMES) acc = 1'b1;
         end else begin
            m_st  = 0;
            m_cnt = 0;
         end
      end else begin
         if (n == 0) begin
            m_cnt++;
            if (m_cnt >= DEB_FRAMES) begin
               m_st  = 0;
               m_cnt = 0;
            end
         end else begin
            m_cnt = 0;
         end
      end
      if (acc) begin
         m_code = m_cand;
         m_st   = 2;
         m_cnt  = 0;
      end
   endtask

   task automatic run_frame(input logic [15:0] mask);
      bit         acc;
      logic       old_held, new_held;
      logic [3:0] old_code, new_code, exp_col;
      old_held = (m_st == 2);
      old_code = m_code;
      model_frame(mask, acc);
      new_held = (m_st == 2);
      new_code = m_code;
      pressed  = mask;
      for (int i = 0; i < FRAME_CLK; i++) begin
         @(posedge clk);
         #1;
         exp_col = ~(4'b0001 << (((i + 1) / SCAN_DIV) % 4));
         check("col", col, exp_col);
         check("col_one_low", 4'($countones(~col)), 4'd1);
         check("key_valid", {3'b0, key_valid}, {3'b0, (i == FRAME_CLK - 1) && acc});
         check("key_held", {3'b0, key_held}, {3'b0, (i == FRAME_CLK - 1) ? new_held : old_held});
         check("key_code", key_code, (i == FRAME_CLK - 1) ? new_code : old_code);
         if (key_valid) dut_pulses++;
      end
      $display("frame mask=%h valid=%0d code=%h held=%0d", mask, acc, new_code, new_held);
   endtask

   task automatic run_frames(input logic [15:0] mask, input int n);
      for (int f = 0; f < n; f++) run_frame(mask);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      check("rst_col", col, 4'b1110);
      check("rst_valid", {3'b0, key_valid}, 4'd0);
      check("rst_held", {3'b0, key_held}, 4'd0);
      check("rst_code", key_code, 4'd0);
      rst = 1'b0;
      model_reset();
      $display("reset released col=%b", col);
   endtask

   initial begin
      int p0;
      int kind, dur, ka, kb;
      do_reset(3);

      // Idle free-run, 100 clk
      run_frames(16'h0000, 5);

      // Key 6 held 10 frames, then released
      p0 = dut_pulses;
      run_frames(16'h0040, 10);
      run_frames(16'h0000, 4);
      check("hold6_pulses", 4'(dut_pulses - p0), 4'd1);
      check("hold6_code", key_code, 4'd6);

      // One-frame bounce
      p0 = dut_pulses;
      run_frames(16'h0040, 1);
      run_frames(16'h0000, 3);
      check("bounce_pulses", 4'(dut_pulses - p0), 4'd0);

      // Keys 0 and 5 together
      p0 = dut_pulses;
      run_frames(16'h0021, 6);
      run_frames(16'h0000, 2);
      check("multi_pulses", 4'(dut_pulses - p0), 4'd0);

      // Key 9: 3-frame release gives two pulses, 2-frame release does not
      p0 = dut_pulses;
      run_frames(16'h0200, 3);
      run_frames(16'h0000, 3);
      run_frames(16'h0200, 3);
      check("rel3_pulses", 4'(dut_pulses - p0), 4'd2);
      check("rel3_code", key_code, 4'd9);
      run_frames(16'h0000, 2);
      run_frames(16'h0200, 3);
      run_frames(16'h0000, 4);
      check("rel2_pulses", 4'(dut_pulses - p0), 4'd2);

      // Second key while held is ignored
      p0 = dut_pulses;
      run_frames(16'h0004, 4);
      run_frames(16'h0084, 3);
      run_frames(16'h0000, 3);
      check("second_key_pulses", 4'(dut_pulses - p0), 4'd1);
      check("second_key_code", key_code, 4'd2);

      // Reset during debounce frame 2
      p0 = dut_pulses;
      run_frames(16'h0008, 1);
      pressed = 16'h0008;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (key_valid) dut_pulses++;
      end
      do_reset(1);
      @(posedge clk);
      #1;
      check("post_rst_col", col, 4'b1110);
      check("post_rst_valid", {3'b0, key_valid}, 4'd0);
      check("abort_pulses", 4'(dut_pulses - p0), 4'd0);
      do_reset(1);
      run_frames(16'h0000, 3);

      // Randomized frame sequences
      for (int s = 0; s < 40; s++) begin
         kind = int'($urandom_range(0, 3));
         dur  = int'($urandom_range(1, 5));
         ka   = int'($urandom_range(0, 15));
         kb   = (ka + int'($urandom_range(1, 15))) % 16;
         case (kind)
            0: run_frames(16'h0000, dur);
            1: run_frames(16'h0001 << ka, dur);
            2: run_frames((16'h0001 << ka) | (16'h0001 << kb), dur);
            default: begin
               run_frames(16'h0001 << ka, dur + 2);
               run_frames((16'h0001 << ka) | (16'h0001 << kb), dur);
            end
         endcase
      end
      run_frames(16'h0000, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
